// File: rtl/matmul_result_writer_if.sv
// Write bus between the result writer and the result memory.
// The master drives the address/data request and the slave answers with ready.
interface matmul_result_writer_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [BUS_WIDTH-1:0]  wr_data_o;
    logic                  wr_ready_i;

    modport master (
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o,
        input  wr_ready_i
    );

    modport slave (
        input  wr_en_o,
        input  wr_addr_o,
        input  wr_data_o,
        output wr_ready_i
    );
endinterface

// File: rtl/matmul_result_writer.sv
// Matrix-multiply result writer.
// Validates the requested dimensions, starts the multiplier, snapshots its
// column-major result matrix and overflow flags, then streams the N x M
// elements row-major over a ready/valid write bus and pulses finish_write_o.
module matmul_result_writer #(
    parameter int  DATA_WIDTH = 8,
    parameter int  BUS_WIDTH  = 16,
    parameter int  ADDR_WIDTH = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 go_i,
    input  logic [2:0]                           n_dim_i,
    input  logic [2:0]                           k_dim_i,
    input  logic [2:0]                           m_dim_i,
    output logic                                 start_o,
    input  logic                                 finish_mul_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] c_matrix_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]           flags_i,
    matmul_result_writer_if.master               wr_if,
    output logic                                 finish_write_o,
    output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int         NUM_EL    = MAX_DIM * MAX_DIM;
    localparam int         IDX_W     = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam logic [2:0] MAX_DIM_D = 3'(MAX_DIM);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WRITE,
        DONE
    } state_t;

    state_t                  state_reg;
    logic [2:0]              n_reg;
    logic [2:0]              m_reg;
    logic [2:0]              row_reg;
    logic [2:0]              col_reg;
    logic                    start_reg;
    logic                    wr_en_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [BUS_WIDTH-1:0]    wr_data_reg;
    logic                    finish_reg;
    logic [NUM_EL-1:0]       flags_reg;
    logic                    err_reg;
    logic [BUS_WIDTH-1:0]    buf_reg [NUM_EL];

    // Result matrix re-ordered so that entry r*MAX_DIM+c holds element (r,c);
    // the multiplier delivers it column-major.
    logic [BUS_WIDTH-1:0]    c_elem [NUM_EL];

    logic                    dims_ok;
    logic                    col_last;
    logic                    row_last;
    logic [2:0]              row_next;
    logic [2:0]              col_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [IDX_W-1:0]        idx_next;

    for (genvar gi = 0; gi < NUM_EL; gi++) begin : g_elem
        localparam int ROW = gi / MAX_DIM;
        localparam int COL = gi % MAX_DIM;
        assign c_elem[gi] = c_matrix_i[(COL*MAX_DIM + ROW)*BUS_WIDTH +: BUS_WIDTH];
    end

    // K only qualifies the request; the write path never needs it afterwards.
    assign dims_ok = (n_dim_i != 3'd0) && (n_dim_i <= MAX_DIM_D) &&
                     (k_dim_i != 3'd0) && (k_dim_i <= MAX_DIM_D) &&
                     (m_dim_i != 3'd0) && (m_dim_i <= MAX_DIM_D);

    // Row-major walk: column advances first, wraps at m-1 and bumps the row.
    always_comb begin
        col_last = (col_reg == m_reg - 3'd1);
        row_last = (row_reg == n_reg - 3'd1);
        row_next = row_reg;
        col_next = col_reg + 3'd1;
        if (col_last) begin
            col_next = 3'd0;
            row_next = row_reg + 3'd1;
        end
        addr_next = ADDR_WIDTH'(int'(row_next) * MAX_DIM + int'(col_next));
        idx_next  = IDX_W'(int'(row_next) * MAX_DIM + int'(col_next));
    end

    // Control FSM with registered outputs; the first element is presented on
    // the capture edge so the bus can accept one element per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            n_reg       <= 3'd0;
            m_reg       <= 3'd0;
            row_reg     <= 3'd0;
            col_reg     <= 3'd0;
            start_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            finish_reg  <= 1'b0;
            flags_reg   <= '0;
            err_reg     <= 1'b0;
            for (int i = 0; i < NUM_EL; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            err_reg    <= 1'b0;
            finish_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go_i) begin
                        if (dims_ok) begin
                            n_reg     <= n_dim_i;
                            m_reg     <= m_dim_i;
                            start_reg <= 1'b1;
                            state_reg <= MUL;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (finish_mul_i) begin
                        buf_reg     <= c_elem;
                        flags_reg   <= flags_i;
                        start_reg   <= 1'b0;
                        row_reg     <= 3'd0;
                        col_reg     <= 3'd0;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= '0;
                        wr_data_reg <= c_elem[0];
                        state_reg   <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_en_reg && wr_if.wr_ready_i) begin
                        if (col_last && row_last) begin
                            wr_en_reg  <= 1'b0;
                            finish_reg <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            row_reg     <= row_next;
                            col_reg     <= col_next;
                            wr_addr_reg <= addr_next;
                            wr_data_reg <= buf_reg[idx_next];
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign start_o         = start_reg;
    assign wr_if.wr_en_o   = wr_en_reg;
    assign wr_if.wr_addr_o = wr_addr_reg;
    assign wr_if.wr_data_o = wr_data_reg;
    assign finish_write_o  = finish_reg;
    assign flags_o         = flags_reg;
    assign err_o           = err_reg;
    assign busy_o          = (state_reg != IDLE);

endmodule
